cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 131 +++++++++++++
 tb/tb_cdb_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit one-entry holding registers, round-robin grant, registered broadcast and free pulses.
// Optional feature macro CDB_BYPASS_EN: lets a unit refill its holding register in the same edge it drains.
module cdb_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ROB_W  = 3,
    parameter int unsigned RD_W   = 4,
    parameter int unsigned RSI_W  = 2
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic [3:0]           ex_valid,
    output logic [3:0]           ex_ready,
    input  logic [4*DATA_W-1:0]  ex_data,
    input  logic [4*ROB_W-1:0]   ex_rob,
    input  logic [4*RD_W-1:0]    ex_rd,
    input  logic [4*RSI_W-1:0]   ex_rsidx,
    input  logic                 flush,
    output logic                 cdb_valid,
    output logic [1:0]           cdb_unit,
    output logic [DATA_W-1:0]    cdb_data,
    output logic [ROB_W-1:0]     cdb_rob,
    output logic [RD_W-1:0]      cdb_rd,
    output logic [RSI_W-1:0]     cdb_rsidx,
    output logic [2:0]           add_free,
    output logic [2:0]           mul_free,
    output logic [3:0]           exec_free
);

    localparam int unsigned NUM_UNITS = 4;
    localparam int unsigned RS_DEPTH  = 3;

    logic [NUM_UNITS-1:0] held;
    logic [DATA_W-1:0]    h_data  [NUM_UNITS];
    logic [ROB_W-1:0]     h_rob   [NUM_UNITS];
    logic [RD_W-1:0]      h_rd    [NUM_UNITS];
    logic [RSI_W-1:0]     h_rsidx [NUM_UNITS];
    logic [1:0]           last_grant;

    logic [NUM_UNITS-1:0] grant;
    logic [1:0]           grant_idx;
    logic                 grant_any;
    logic [1:0]           cand;
    logic [2:0]           rs_onehot;
    logic [NUM_UNITS-1:0] capture;

    // Round-robin search starting one past the last granted unit
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = 2'(last_grant + 2'(k) + 2'd1);
            if (!grant_any && held[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant = grant_any ? 4'(4'b0001 << grant_idx) : 4'b0000;
    end

    // RS entry to free; index 3 has no entry behind it
    always_comb begin
        rs_onehot = 3'b000;
        for (int j = 0; j < RS_DEPTH; j++) begin
            if (grant_any && h_rsidx[grant_idx] == RSI_W'(j)) begin
                rs_onehot[j] = 1'b1;
            end
        end
    end

`ifdef CDB_BYPASS_EN
    assign ex_ready = ~held | grant;
`else
    assign ex_ready = ~held;
`endif

    assign capture = ex_valid & ex_ready;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            held       <= '0;
            last_grant <= 2'd3;
            cdb_valid  <= 1'b0;
            cdb_unit   <= 2'd0;
            cdb_data   <= '0;
            cdb_rob    <= '0;
            cdb_rd     <= '0;
            cdb_rsidx  <= '0;
            add_free   <= 3'b000;
            mul_free   <= 3'b000;
            exec_free  <= 4'b0000;
            for (int i = 0; i < NUM_UNITS; i++) begin
                h_data[i]  <= '0;
                h_rob[i]   <= '0;
                h_rd[i]    <= '0;
                h_rsidx[i] <= '0;
            end
        end else if (flush) begin
            held      <= '0;
            cdb_valid <= 1'b0;
            add_free  <= 3'b000;
            mul_free  <= 3'b000;
            exec_free <= 4'b0000;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (capture[i]) begin
                    held[i]    <= 1'b1;
                    h_data[i]  <= ex_data[i*DATA_W +: DATA_W];
                    h_rob[i]   <= ex_rob[i*ROB_W +: ROB_W];
                    h_rd[i]    <= ex_rd[i*RD_W +: RD_W];
                    h_rsidx[i] <= ex_rsidx[i*RSI_W +: RSI_W];
                end else if (grant[i]) begin
                    held[i] <= 1'b0;
                end
            end
            cdb_valid <= grant_any;
            exec_free <= grant;
            add_free  <= grant_idx[1] ? 3'b000 : rs_onehot;
            mul_free  <= grant_idx[1] ? rs_onehot : 3'b000;
            if (grant_any) begin
                last_grant <= grant_idx;
                cdb_unit   <= grant_idx;
                cdb_data   <= h_data[grant_idx];
                cdb_rob    <= h_rob[grant_idx];
                cdb_rd     <= h_rd[grant_idx];
                cdb_rsidx  <= h_rsidx[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues expected broadcasts, a monitor pops and compares each one.
module tb_cdb_arbiter;

    logic        clk1;
    logic        rst_n;
    logic [3:0]  ex_valid;
    logic [3:0]  ex_ready;
    logic [63:0] ex_data;
    logic [11:0] ex_rob;
    logic [15:0] ex_rd;
    logic [7:0]  ex_rsidx;
    logic        flush;
    logic        cdb_valid;
    logic [1:0]  cdb_unit;
    logic [15:0] cdb_data;
    logic [2:0]  cdb_rob;
    logic [3:0]  cdb_rd;
    logic [1:0]  cdb_rsidx;
    logic [2:0]  add_free;
    logic [2:0]  mul_free;
    logic [3:0]  exec_free;

    typedef struct packed {
        logic [1:0]  unit;
        logic [15:0] data;
        logic [2:0]  rob;
        logic [3:0]  rd;
        logic [1:0]  rsidx;
        logic [3:0]  ef;
        logic [2:0]  af;
        logic [2:0]  mf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef CDB_BYPASS_EN
    localparam logic [5:0] STREAM_ACC = 6'b111111;
`else
    localparam logic [5:0] STREAM_ACC = 6'b010101;
`endif

    cdb_arbiter dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_data   (ex_data),
        .ex_rob    (ex_rob),
        .ex_rd     (ex_rd),
        .ex_rsidx  (ex_rsidx),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_unit  (cdb_unit),
        .cdb_data  (cdb_data),
        .cdb_rob   (cdb_rob),
        .cdb_rd    (cdb_rd),
        .cdb_rsidx (cdb_rsidx),
        .add_free  (add_free),
        .mul_free  (mul_free),
        .exec_free (exec_free)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic clear_inputs();
        ex_valid = '0;
        ex_data  = '0;
        ex_rob   = '0;
        ex_rd    = '0;
        ex_rsidx = '0;
    endtask

    task automatic set_unit(input int u, input logic [15:0] d, input logic [2:0] rob,
                            input logic [3:0] rd, input logic [1:0] rsi);
        ex_valid[u]          = 1'b1;
        ex_data[u*16 +: 16]  = d;
        ex_rob[u*3 +: 3]     = rob;
        ex_rd[u*4 +: 4]      = rd;
        ex_rsidx[u*2 +: 2]   = rsi;
    endtask

    task automatic push_exp(input logic [1:0] u, input logic [15:0] d, input logic [2:0] rob,
                            input logic [3:0] rd, input logic [1:0] rsi,
                            input logic [3:0] ef, input logic [2:0] af, input logic [2:0] mf);
        exp_t e;
        e = '{unit: u, data: d, rob: rob, rd: rd, rsidx: rsi, ef: ef, af: af, mf: mf};
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        clear_inputs();
        #3 rst_n = 1'b1;
        @(posedge clk1);
        #1;
    endtask

    // Monitor: compare every broadcast against the head of the scoreboard
    initial begin
        exp_t act;
        exp_t req;
        forever begin
            @(negedge clk1);
            if (rst_n) begin
                if (cdb_valid) begin
                    act = '{unit: cdb_unit, data: cdb_data, rob: cdb_rob, rd: cdb_rd, rsidx: cdb_rsidx,
                            ef: exec_free, af: add_free, mf: mul_free};
                    if (exp_q.size() == 0) begin
                        check("unexpected_broadcast", 64'(act), 64'(0));
                    end else begin
                        req = exp_q.pop_front();
                        check("broadcast", 64'(act), 64'(req));
                    end
                end else begin
                    check("idle_free_pulses", 64'({exec_free, add_free, mul_free}), 64'(0));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        clear_inputs();
        #12;
        check("reset_state", 64'({cdb_valid, cdb_unit, cdb_data, cdb_rob, cdb_rd, cdb_rsidx}), 64'(0));
        check("reset_ready_free", 64'({ex_ready, exec_free, add_free, mul_free}), 64'({4'b1111, 10'b0}));
        #1 rst_n = 1'b1;
        @(posedge clk1);
        #1;

        // Single result from unit 0
        set_unit(0, 16'h00AA, 3'd5, 4'd3, 2'd1);
        push_exp(2'd0, 16'h00AA, 3'd5, 4'd3, 2'd1, 4'b0001, 3'b010, 3'b000);
        @(posedge clk1);
        #1;
        clear_inputs();
        check("ready_after_capture", 64'(ex_ready), 64'(4'b1110));
        repeat (3) @(posedge clk1);
        #1;

        // Four simultaneous captures drain 0,1,2,3
        do_reset();
        set_unit(0, 16'h1111, 3'd1, 4'd1, 2'd0);
        set_unit(1, 16'h2222, 3'd2, 4'd2, 2'd1);
        set_unit(2, 16'h3333, 3'd3, 4'd3, 2'd2);
        set_unit(3, 16'h4444, 3'd4, 4'd4, 2'd0);
        push_exp(2'd0, 16'h1111, 3'd1, 4'd1, 2'd0, 4'b0001, 3'b001, 3'b000);
        push_exp(2'd1, 16'h2222, 3'd2, 4'd2, 2'd1, 4'b0010, 3'b010, 3'b000);
        push_exp(2'd2, 16'h3333, 3'd3, 4'd3, 2'd2, 4'b0100, 3'b000, 3'b100);
        push_exp(2'd3, 16'h4444, 3'd4, 4'd4, 2'd0, 4'b1000, 3'b000, 3'b001);
        @(posedge clk1);
        #1;
        clear_inputs();
        repeat (6) @(posedge clk1);
        #1;

        // Unit 2 streams for 6 cycles
        for (int k = 0; k < 6; k++) begin
            set_unit(2, 16'h5000 + 16'(k), 3'(k), 4'(k + 8), 2'd0);
            check("stream_ready", 64'(ex_ready[2]), 64'(STREAM_ACC[k]));
            if (STREAM_ACC[k]) begin
                push_exp(2'd2, 16'h5000 + 16'(k), 3'(k), 4'(k + 8), 2'd0, 4'b0100, 3'b000, 3'b001);
            end
            @(posedge clk1);
            #1;
        end
        clear_inputs();
        repeat (4) @(posedge clk1);
        #1;

        // Hold units 1 and 3, then flush
        set_unit(1, 16'hDEAD, 3'd1, 4'd1, 2'd0);
        set_unit(3, 16'hBEEF, 3'd3, 4'd3, 2'd1);
        @(posedge clk1);
        #1;
        clear_inputs();
        flush = 1'b1;
        @(posedge clk1);
        #1;
        flush = 1'b0;
        check("flush_state", 64'({cdb_valid, ex_ready, exec_free, add_free, mul_free}),
              64'({1'b0, 4'b1111, 10'b0}));
        repeat (3) @(posedge clk1);
        #1;

        // Out-of-range RS index from unit 0
        set_unit(0, 16'hABCD, 3'd6, 4'd7, 2'd3);
        push_exp(2'd0, 16'hABCD, 3'd6, 4'd7, 2'd3, 4'b0001, 3'b000, 3'b000);
        @(posedge clk1);
        #1;
        clear_inputs();
        repeat (3) @(posedge clk1);
        #1;

        // Units 0 and 3 together after unit 0 was last granted: 3 wins, then wrap to 0
        set_unit(0, 16'h8888, 3'd2, 4'd2, 2'd2);
        set_unit(3, 16'h7777, 3'd1, 4'd1, 2'd2);
        push_exp(2'd3, 16'h7777, 3'd1, 4'd1, 2'd2, 4'b1000, 3'b000, 3'b100);
        push_exp(2'd0, 16'h8888, 3'd2, 4'd2, 2'd2, 4'b0001, 3'b100, 3'b000);
        @(posedge clk1);
        #1;
        clear_inputs();
        repeat (4) @(posedge clk1);
        #1;

        // Asynchronous reset in the middle of a broadcast
        set_unit(1, 16'hCAFE, 3'd7, 4'd9, 2'd1);
        @(posedge clk1);
        #1;
        clear_inputs();
        @(posedge clk1);
        #1;
        check("pre_reset_broadcast", 64'({cdb_valid, cdb_unit}), 64'({1'b1, 2'd1}));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_clear", 64'({cdb_valid, exec_free, add_free, cdb_data, cdb_rob, cdb_rd, cdb_rsidx}),
              64'(0));
        check("async_reset_ready", 64'(ex_ready), 64'(4'b1111));
        #4 rst_n = 1'b1;
        @(posedge clk1);
        #1;
        repeat (3) @(posedge clk1);
        #1;

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
            @(posedge clk1);
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
